alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset: clk input 1 (rising edge), rst_n input 1 (asynchronous, active-low).
REQ-002 The block SHALL provide these instruction ports: ins_valid input 1; ins_ready output 1; ins_op input 4 (ALU control code); ins_rd input 3; ins_rs1 input 3; ins_rs2 input 3; ins_imm input 16.
REQ-003 The block SHALL provide these ALU ports: alu_a output 16; alu_b output 16; alu_ctrl output 4; alu_result input 16 (from the combinational 16-bit ALU).
REQ-004 The block SHALL provide these writeback ports: wb_valid output 1; wb_rd output 3; wb_data output 16.
REQ-005 The block SHALL provide these status ports: div_zero output 1; illegal_op output 1.
REQ-006 The block SHALL provide these debug ports: dbg_addr input 3; dbg_data output 16 (combinational register-file read).

Function
REQ-007 The block SHALL contain a register file of 8 x 16 bits, where r0 always reads 0 and writes to r0 are dropped.
REQ-008 The block SHALL implement an FSM with states IDLE, EXEC and WB, with transitions IDLE->EXEC on ins_valid&&ins_ready, EXEC->WB unconditionally, and WB->IDLE unconditionally.
REQ-009 The block SHALL drive ins_ready = 1 only in IDLE; a transfer occurs only on clk rise with ins_valid=1 and ins_ready=1.
REQ-010 On transfer, the block SHALL latch op, rd, imm, and the contents of rs1 and rs2 (read at the transfer edge) into internal operand registers.
REQ-011 In EXEC, the block SHALL drive alu_ctrl = latched op and alu_b = rs2 value; alu_a SHALL be imm when op = 1010 (LOADI), and the rs1 value otherwise.
REQ-012 Outside EXEC, the block SHALL hold alu_a, alu_b and alu_ctrl at 0.
REQ-013 At the end of EXEC, the block SHALL capture the result: alu_result normally; 16'hFFFF when op is 0111 (DIV) or 1001 (MOD) and alu_b = 0.
REQ-014 In WB, the block SHALL assert wb_valid for exactly one cycle, with wb_rd = latched rd and wb_data = the captured result.
REQ-015 In WB, the block SHALL write the captured result to rd, unless rd = 0 or the op is illegal.
REQ-016 Latency SHALL be fixed: transfer at edge N, then wb_valid high in cycle N+2, then ins_ready high again in cycle N+3.
REQ-017 Throughput SHALL be one instruction per 3 cycles; there is no overlap and no hazards.
REQ-018 An instruction whose rs equals the previous instruction's rd SHALL read the written value, because the write completes before the next transfer.
REQ-019 div_zero SHALL pulse for 1 cycle, coincident with wb_valid, for DIV or MOD with divisor 0.
REQ-020 Illegal ops are 0110 and 1011-1111; for these, illegal_op SHALL pulse with wb_valid, wb_data = 0, and no register write occurs.
REQ-021 wb_rd, wb_data and the flag outputs SHALL be 0 in every cycle where wb_valid = 0.
REQ-022 dbg_data SHALL reflect a register write on the cycle after the WB edge.

Reset
REQ-023 On rst_n low, the block SHALL immediately force: state to IDLE; all registers, operand latches and the captured result to 0; wb_valid, wb_rd, wb_data, div_zero, illegal_op to 0; and alu_a, alu_b, alu_ctrl to 0.
REQ-024 If reset asserts during EXEC or WB, the block SHALL abort the in-flight instruction with no register write and no wb_valid.
REQ-025 While rst_n is low, no transfer SHALL be recorded; after release, ins_ready SHALL be 1 in the first cycle.

Configuration
REQ-026 Macro ALU_FLAGS_EN, when defined, SHALL add outputs wb_zero (1 bit) and wb_neg (1 bit), valid with wb_valid: wb_zero = (wb_data == 0) and wb_neg = wb_data[15]; both SHALL be 0 otherwise and reset to 0.
REQ-027 With ALU_FLAGS_EN undefined, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Reset scenario: reset, then LOADI rd=1 imm=0x1234 -> wb_valid 2 cycles after transfer, wb_rd=1, wb_data=0x1234, dbg_addr=1 reads 0x1234 afterwards.
REQ-029 Dependent ADD/SUB scenario: r1=0x0005, r2=0x0003; ADD rd=3, rs1=1, rs2=2 gives 0x0008; then SUB rd=4, rs1=2, rs2=1 gives 0xFFFE (wrap); r3 and r4 read back correctly.
REQ-030 Divide-by-zero scenario: DIV rd=5 with r1=0x0010 and rs2=r0 -> wb_data=0xFFFF, div_zero=1 for one cycle, r5=0xFFFF; MOD with a divisor of 0 behaves identically.
REQ-031 Illegal-op and r0 scenario: op=0110 rd=2 -> illegal_op=1, wb_data=0, r2 unchanged; ADD rd=0 -> wb_valid=1, r0 still reads 0.
REQ-032 Handshake scenario: ins_valid held high continuously -> ins_ready pattern 1,0,0 repeating, one transfer per 3 cycles, no instruction dropped or duplicated.
REQ-033 Mid-operation reset scenario: assert rst_n low in EXEC of ADD rd=6 -> no wb_valid, r6=0 after release, ins_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Three-state (IDLE/EXEC/WB) execute stage with an 8x16 register file driving an external ALU.
// Optional macro ALU_FLAGS_EN adds wb_zero/wb_neg result flags alongside wb_valid.
module alu_exec_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ins_valid,
  output logic        ins_ready,
  input  logic [3:0]  ins_op,
  input  logic [2:0]  ins_rd,
  input  logic [2:0]  ins_rs1,
  input  logic [2:0]  ins_rs2,
  input  logic [15:0] ins_imm,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [15:0] alu_result,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        div_zero,
  output logic        illegal_op,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
`ifdef ALU_FLAGS_EN
  ,
  output logic        wb_zero,
  output logic        wb_neg
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [3:0] OP_DIV   = 4'b0111;
  localparam logic [3:0] OP_MOD   = 4'b1001;
  localparam logic [3:0] OP_LOADI = 4'b1010;

  logic [1:0]  r_state;
  logic [2:0]  r_rd;
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [3:0]  r_alu_ctrl;
  logic        r_wb_valid;
  logic [2:0]  r_wb_rd;
  logic [15:0] r_wb_data;
  logic        r_div_zero;
  logic        r_illegal_op;
  logic [15:0] r_rf [8];
`ifdef ALU_FLAGS_EN
  logic        r_wb_zero;
  logic        r_wb_neg;
`endif

  logic        w_div_zero;
  logic        w_illegal;
  logic [15:0] w_result;

  // Result selection at the end of EXEC; operands live in the alu_* registers during EXEC.
  always_comb begin
    w_div_zero = ((r_alu_ctrl == OP_DIV) || (r_alu_ctrl == OP_MOD)) && (r_alu_b == 16'h0000);
    w_illegal  = (r_alu_ctrl == 4'b0110) || (r_alu_ctrl >= 4'b1011);
    if (w_illegal) begin
      w_result = 16'h0000;
    end else if (w_div_zero) begin
      w_result = 16'hFFFF;
    end else begin
      w_result = alu_result;
    end
  end

  // Control FSM, operand latching and registered writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rd         <= 3'd0;
      r_alu_a      <= 16'h0000;
      r_alu_b      <= 16'h0000;
      r_alu_ctrl   <= 4'd0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= 3'd0;
      r_wb_data    <= 16'h0000;
      r_div_zero   <= 1'b0;
      r_illegal_op <= 1'b0;
`ifdef ALU_FLAGS_EN
      r_wb_zero    <= 1'b0;
      r_wb_neg     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ins_valid) begin
            r_state    <= S_EXEC;
            r_rd       <= ins_rd;
            r_alu_ctrl <= ins_op;
            r_alu_a    <= (ins_op == OP_LOADI) ? ins_imm : r_rf[ins_rs1];
            r_alu_b    <= r_rf[ins_rs2];
          end
        end
        S_EXEC: begin
          r_state      <= S_WB;
          r_alu_a      <= 16'h0000;
          r_alu_b      <= 16'h0000;
          r_alu_ctrl   <= 4'd0;
          r_wb_valid   <= 1'b1;
          r_wb_rd      <= r_rd;
          r_wb_data    <= w_result;
          r_div_zero   <= w_div_zero;
          r_illegal_op <= w_illegal;
`ifdef ALU_FLAGS_EN
          r_wb_zero    <= (w_result == 16'h0000);
          r_wb_neg     <= w_result[15];
`endif
        end
        S_WB: begin
          r_state      <= S_IDLE;
          r_wb_valid   <= 1'b0;
          r_wb_rd      <= 3'd0;
          r_wb_data    <= 16'h0000;
          r_div_zero   <= 1'b0;
          r_illegal_op <= 1'b0;
`ifdef ALU_FLAGS_EN
          r_wb_zero    <= 1'b0;
          r_wb_neg     <= 1'b0;
`endif
        end
        default: begin
          r_state    <= S_IDLE;
          r_alu_a    <= 16'h0000;
          r_alu_b    <= 16'h0000;
          r_alu_ctrl <= 4'd0;
          r_wb_valid <= 1'b0;
        end
      endcase
    end
  end

  // Register file write on the WB edge; r0 is never written so it reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_rf[i] <= 16'h0000;
      end
    end else if ((r_state == S_WB) && (r_wb_rd != 3'd0) && !r_illegal_op) begin
      r_rf[r_wb_rd] <= r_wb_data;
    end
  end

  assign ins_ready  = (r_state == S_IDLE);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_ctrl   = r_alu_ctrl;
  assign wb_valid   = r_wb_valid;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign div_zero   = r_div_zero;
  assign illegal_op = r_illegal_op;
  assign dbg_data   = r_rf[dbg_addr];
`ifdef ALU_FLAGS_EN
  assign wb_zero    = r_wb_zero;
  assign wb_neg     = r_wb_neg;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: a local ALU model answers alu_result, expected writebacks are queued at issue.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [3:0]  ins_op = 4'd0;
  logic [2:0]  ins_rd = 3'd0;
  logic [2:0]  ins_rs1 = 3'd0;
  logic [2:0]  ins_rs2 = 3'd0;
  logic [15:0] ins_imm = 16'h0000;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [15:0] alu_result;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        div_zero;
  logic        illegal_op;
  logic [2:0]  dbg_addr = 3'd0;
  logic [15:0] dbg_data;
`ifdef ALU_FLAGS_EN
  logic        wb_zero;
  logic        wb_neg;
`endif

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    logic        dz;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_rf [8];
  int          n_checks = 0;
  int          n_errors = 0;

  alu_exec_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op), .ins_rd(ins_rd),
    .ins_rs1(ins_rs1), .ins_rs2(ins_rs2), .ins_imm(ins_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .div_zero(div_zero), .illegal_op(illegal_op),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_FLAGS_EN
    , .wb_zero(wb_zero), .wb_neg(wb_neg)
`endif
  );

  always #5 clk = ~clk;

  // External ALU: deliberately returns junk on divide-by-zero and illegal codes.
  function automatic logic [15:0] tb_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0100: return a ^ b;
      4'b0101: return a << b[3:0];
      4'b0111: return (b == 16'h0000) ? 16'hBEEF : a / b;
      4'b1000: return a * b;
      4'b1001: return (b == 16'h0000) ? 16'hBEEF : a % b;
      4'b1010: return a;
      default: return 16'hDEAD;
    endcase
  endfunction

  assign alu_result = tb_alu(alu_ctrl, alu_a, alu_b);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Writeback monitor: pop the scoreboard on each wb_valid, otherwise outputs must be quiet.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid) begin
        if (sb.size() == 0) begin
          check_eq("wb_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("wb_rd", {29'd0, wb_rd}, {29'd0, e.rd});
          check_eq("wb_data", {16'd0, wb_data}, {16'd0, e.data});
          check_eq("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
          check_eq("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
`ifdef ALU_FLAGS_EN
          check_eq("wb_zero", {31'd0, wb_zero}, {31'd0, (e.data == 16'h0000)});
          check_eq("wb_neg", {31'd0, wb_neg}, {31'd0, e.data[15]});
`endif
          if ((e.rd != 3'd0) && !e.ill) m_rf[e.rd] = e.data;
        end
      end else begin
        check_eq("quiet_wb", {11'd0, wb_rd, wb_data, div_zero, illegal_op}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [15:0] imm, input bit keep_valid,
                       input bit push, output int waited);
    exp_t        e;
    logic [15:0] a;
    logic [15:0] b;
    waited = 0;
    @(negedge clk);
    while (!ins_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("ready_wait", {31'd0, ins_ready}, 32'd1);
    check_eq("alu_idle_zero", {12'd0, alu_ctrl, alu_a}, 32'd0);
    a = (op == 4'b1010) ? imm : m_rf[rs1];
    b = m_rf[rs2];
    e.rd  = rd;
    e.dz  = ((op == 4'b0111) || (op == 4'b1001)) && (b == 16'h0000);
    e.ill = (op == 4'b0110) || (op >= 4'b1011);
    e.data = e.ill ? 16'h0000 : (e.dz ? 16'hFFFF : tb_alu(op, a, b));
    if (push) sb.push_back(e);
    ins_valid = 1'b1;
    ins_op = op; ins_rd = rd; ins_rs1 = rs1; ins_rs2 = rs2; ins_imm = imm;
    @(posedge clk);
    #1;
    if (!keep_valid) ins_valid = 1'b0;
    check_eq("exec_ctrl", {28'd0, alu_ctrl}, {28'd0, op});
    check_eq("exec_a", {16'd0, alu_a}, {16'd0, a});
    check_eq("exec_b", {16'd0, alu_b}, {16'd0, b});
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !ins_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", sb.size(), 32'd0);
  endtask

  task automatic check_reg(input logic [2:0] addr, input logic [15:0] exp, input string tag);
    dbg_addr = addr;
    #1;
    check_eq(tag, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w;
    logic [15:0] v;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;

    // Reset with a pending request that must not be taken.
    ins_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_wb", {15'd0, wb_valid, wb_data}, 32'd0);
    check_eq("rst_alu", {12'd0, alu_ctrl, alu_a}, 32'd0);
    ins_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_eq("rst_ready", {31'd0, ins_ready}, 32'd1);
    check_reg(3'd1, 16'h0000, "rst_r1");

    issue(4'b1010, 3'd1, 3'd0, 3'd0, 16'h1234, 1'b0, 1'b1, w);
    @(negedge clk);
    check_eq("lat_exec_nowb", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check_eq("lat_wb", {31'd0, wb_valid}, 32'd1);
    @(negedge clk);
    check_eq("lat_ready", {31'd0, ins_ready}, 32'd1);
    check_reg(3'd1, 16'h1234, "r1_loadi");

    // Dependent arithmetic chain.
    issue(4'b1010, 3'd1, 3'd0, 3'd0, 16'h0005, 1'b0, 1'b1, w);
    issue(4'b1010, 3'd2, 3'd0, 3'd0, 16'h0003, 1'b0, 1'b1, w);
    issue(4'b0000, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b1, w);
    issue(4'b0001, 3'd4, 3'd2, 3'd1, 16'h0000, 1'b0, 1'b1, w);
    issue(4'b0000, 3'd5, 3'd3, 3'd4, 16'h0000, 1'b0, 1'b1, w);
    drain();
    check_reg(3'd3, 16'h0008, "r3_add");
    check_reg(3'd4, 16'hFFFE, "r4_sub");
    check_reg(3'd5, 16'h0006, "r5_dep");

    // Divide / modulo, with and without a zero divisor.
    issue(4'b1010, 3'd1, 3'd0, 3'd0, 16'h0010, 1'b0, 1'b1, w);
    issue(4'b0111, 3'd5, 3'd1, 3'd0, 16'h0000, 1'b0, 1'b1, w);
    issue(4'b1001, 3'd7, 3'd1, 3'd0, 16'h0000, 1'b0, 1'b1, w);
    issue(4'b0111, 3'd6, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b1, w);
    issue(4'b1001, 3'd4, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b1, w);
    drain();
    check_reg(3'd5, 16'hFFFF, "r5_div0");
    check_reg(3'd7, 16'hFFFF, "r7_mod0");
    check_reg(3'd6, 16'h0005, "r6_div");
    check_reg(3'd4, 16'h0001, "r4_mod");

    // Illegal codes and writes to r0.
    issue(4'b0110, 3'd2, 3'd1, 3'd1, 16'h0000, 1'b0, 1'b1, w);
    issue(4'b1111, 3'd2, 3'd1, 3'd1, 16'h0000, 1'b0, 1'b1, w);
    issue(4'b0000, 3'd0, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b1, w);
    drain();
    check_reg(3'd2, 16'h0003, "r2_kept");
    check_reg(3'd0, 16'h0000, "r0_zero");

    // Continuous ins_valid: one acceptance every third cycle.
    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom_range(0, 65535));
      case (i % 4)
        0: issue(4'b1010, 3'(1 + i % 7), 3'd0, 3'd0, v, 1'b1, 1'b1, w);
        1: issue(4'b0100, 3'd3, 3'(i % 8), 3'd2, 16'h0000, 1'b1, 1'b1, w);
        2: issue(4'b1000, 3'd4, 3'd3, 3'd1, 16'h0000, 1'b1, 1'b1, w);
        default: issue(4'b0101, 3'd5, 3'd4, 3'd2, 16'h0000, 1'b1, 1'b1, w);
      endcase
      if (i > 0) check_eq("b2b_gap", w, 32'd2);
    end
    ins_valid = 1'b0;
    drain();
    check_reg(3'd3, m_rf[3], "r3_b2b");
    check_reg(3'd5, m_rf[5], "r5_b2b");

    // Reset during EXEC aborts the instruction.
    issue(4'b0000, 3'd6, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b0, w);
    rst_n = 1'b0;
    #1;
    check_eq("abort_quiet", {15'd0, wb_valid, alu_a}, 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    rst_n = 1'b1;
    #1;
    check_eq("abort_ready", {31'd0, ins_ready}, 32'd1);
    check_reg(3'd6, 16'h0000, "r6_abort");
    check_reg(3'd1, 16'h0000, "r1_cleared");
    issue(4'b1010, 3'd6, 3'd0, 3'd0, 16'h8000, 1'b0, 1'b1, w);
    drain();
    check_reg(3'd6, 16'h8000, "r6_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
